// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - default address/data widths used by the interface and the top
//   - arbiter FSM state type
//   - lock counter width (covers MAX_LOCK up to 255)
package dmem_arb_pkg;

    localparam int unsigned DefAddrW = 10;
    localparam int unsigned DefDataW = 32;
    localparam int unsigned LockCntW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesting ports, the arbiter and a data memory.
// Ports (per requester N = 0,1):
//   mN_req/we/lock/addr/wdata : request side, driven by the requester
//   mN_gnt                    : access accepted this cycle (from arbiter)
//   mN_rvalid/rdata           : read response, one cycle after a read grant
// Memory side:
//   mem_addr/wdata/we         : access presented to the memory (from arbiter)
//   mem_rdata                 : registered read data from the memory
// Modports: slave = arbiter view, master = requesters + memory view.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
);

    logic              m0_req;
    logic              m0_we;
    logic              m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick.
//   req0, req1 : requests
//   last_gnt   : port that won the previous grant (1 -> port 0 wins a tie)
//   gnt0, gnt1 : one-hot (or zero) pick
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = req0 & (~req1 | last_gnt);
        gnt1 = req1 & (~req0 | ~last_gnt);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with round-robin fairness and bounded locking.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : synchronous active-low reset
//   bus   : dmem_arbiter_if slave modport (requesters + memory)
// A port may hold ownership via mN_lock for at most MAX_LOCK consecutive
// grants; read data returns with a fixed latency of one cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    localparam bit                  LockEn   = (MAX_LOCK > 1);
    localparam logic [LockCntW-1:0] MaxLockC = LockCntW'(MAX_LOCK);

    arb_state_e          state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic [LockCntW-1:0] cnt_q, cnt_d;
    logic [1:0]          rvalid_q;

    logic                pick0, pick1;
    logic                gnt0, gnt1;
    logic [LockCntW-1:0] cnt_inc;

    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic                win_we;

    rr_pick2 u_rr_pick2 (
        .req0     (bus.m0_req),
        .req1     (bus.m1_req),
        .last_gnt (last_gnt_q),
        .gnt0     (pick0),
        .gnt1     (pick1)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= {gnt1 & ~bus.m1_we, gnt0 & ~bus.m0_we};
        end
    end

    assign cnt_inc = cnt_q + LockCntW'(1);

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;

        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (gnt0 && bus.m0_lock && LockEn) begin
                    state_d = LOCK0;
                    cnt_d   = LockCntW'(1);
                end else if (gnt1 && bus.m1_lock && LockEn) begin
                    state_d = LOCK1;
                    cnt_d   = LockCntW'(1);
                end
            end
            LOCK0: begin
                // Owner dropping req, releasing lock or hitting the cap all return to IDLE
                if (!gnt0 || !bus.m0_lock || cnt_inc >= MaxLockC) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LOCK1: begin
                if (!gnt1 || !bus.m1_lock || cnt_inc >= MaxLockC) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: grants and memory mux
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    gnt0 = pick0;
                    gnt1 = pick1;
                end
                LOCK0:   gnt0 = bus.m0_req;
                LOCK1:   gnt1 = bus.m1_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        if (gnt0) begin
            win_addr  = bus.m0_addr;
            win_wdata = bus.m0_wdata;
            win_we    = bus.m0_we;
        end else if (gnt1) begin
            win_addr  = bus.m1_addr;
            win_wdata = bus.m1_wdata;
            win_we    = bus.m1_we;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.mem_addr  = win_addr;
    assign bus.mem_wdata = win_wdata;
    assign bus.mem_we    = win_we;

    // Responses are masked while reset is held so a read granted just before
    // reset never shows up as valid.
    assign bus.m0_rvalid = rvalid_q[0] & rst_n;
    assign bus.m1_rvalid = rvalid_q[1] & rst_n;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int ML = 8;
    localparam int MEM_WORDS = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Environment memory: registered read, old data on same-cycle write
    logic [DW-1:0] mem [MEM_WORDS];
    bit preloaded = 1'b0;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 'h3D0) return 32'd2001;
        return (i * 32'h9E3779B1) ^ 32'h0000_5A5A;
    endfunction

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_val(i);
            preloaded <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [MEM_WORDS];
    int m_owner;   // -1: nobody holds a lock
    int m_run;     // consecutive grants within the current lock
    int m_last;    // port granted most recently

    typedef struct {
        int            tag;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t rq [2][$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_g   = -1;
    int hist [$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_port(input int p, input bit req, input bit we, input bit lock,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock;
            bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock;
            bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    task automatic idle_ports();
        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 0, 0, 0, '0, '0);
    endtask

    // Predicts the grant from the arbitration rules, checks the combinational
    // outputs, queues the expected read response and advances the model.
    task automatic check_cycle();
        logic          req [2];
        logic          we [2];
        logic          lk [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        int g, act;
        req[0] = bus.m0_req; we[0] = bus.m0_we; lk[0] = bus.m0_lock;
        ad[0] = bus.m0_addr; wd[0] = bus.m0_wdata;
        req[1] = bus.m1_req; we[1] = bus.m1_we; lk[1] = bus.m1_lock;
        ad[1] = bus.m1_addr; wd[1] = bus.m1_wdata;

        g = -1;
        if (rst_n) begin
            if (m_owner >= 0) g = req[m_owner] ? m_owner : -1;
            else if (req[0] && req[1]) g = 1 - m_last;
            else if (req[0]) g = 0;
            else if (req[1]) g = 1;
        end

        chk("m0_gnt", bus.m0_gnt, (g == 0));
        chk("m1_gnt", bus.m1_gnt, (g == 1));
        chk("mem_we", bus.mem_we, (g >= 0) ? we[g] : 1'b0);
        chk("mem_addr", bus.mem_addr, (g >= 0) ? ad[g] : '0);
        chk("mem_wdata", bus.mem_wdata, (g >= 0) ? wd[g] : '0);

        act = bus.m0_gnt ? (bus.m1_gnt ? 2 : 0) : (bus.m1_gnt ? 1 : -1);
        hist.push_back(act);
        last_g = g;

        if (g >= 0) begin
            if (!we[g]) begin
                rsp_t r;
                r.tag  = cyc;
                r.data = ref_mem[ad[g]];
                rq[g].push_back(r);
            end else begin
                ref_mem[ad[g]] = wd[g];
            end
        end

        if (!rst_n) begin
            m_owner = -1; m_run = 0; m_last = 1;
        end else if (m_owner >= 0) begin
            if (g < 0) begin
                m_owner = -1;
            end else begin
                m_run++;
                m_last = g;
                if (!lk[g] || m_run >= ML) m_owner = -1;
            end
        end else if (g >= 0) begin
            m_last = g;
            if (lk[g] && ML > 1) begin
                m_owner = g; m_run = 1;
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Response monitor: sampled between the input update and the grant check
    task automatic mon_port(input int p);
        logic          rv;
        logic [DW-1:0] rd;
        rv = (p == 0) ? bus.m0_rvalid : bus.m1_rvalid;
        rd = (p == 0) ? bus.m0_rdata : bus.m1_rdata;
        while (rq[p].size() > 0 && rq[p][0].tag < cyc - 1) begin
            checks++;
            failures++;
            $display("FAIL rsp_missing port=%0d tag=%0d actual=none required=%0h",
                     p, rq[p][0].tag, rq[p][0].data);
            void'(rq[p].pop_front());
        end
        if (rst_n === 1'b0) begin
            chk($sformatf("rvalid_in_reset_p%0d", p), rv, 0);
            if (rq[p].size() > 0 && rq[p][0].tag == cyc - 1) void'(rq[p].pop_front());
        end else if (rq[p].size() > 0 && rq[p][0].tag == cyc - 1) begin
            chk($sformatf("rvalid_p%0d", p), rv, 1);
            chk($sformatf("rdata_p%0d", p), rd, rq[p][0].data);
            void'(rq[p].pop_front());
        end else begin
            chk($sformatf("rvalid_idle_p%0d", p), rv, 0);
            chk($sformatf("rdata_idle_p%0d", p), rd, 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #3;
            mon_port(0);
            mon_port(1);
        end
    end

    task automatic check_hist(input string nm, input int start, input int exp []);
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), hist[start + i], exp[i]);
    endtask

    initial begin
        int s, rem, n;
        int exp_lock [];
        int exp_drop [];
        int exp_rst [];
        bit pend [2];

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);
        m_owner = -1; m_run = 0; m_last = 1;
        rst_n = 1'b0;
        idle_ports();
        @(posedge clk);
        #1;

        // Reset, with requests present: no grants while held
        for (int i = 0; i < 3; i++) begin
            set_port(0, 1, 0, 1, 10'h3D0, '0);
            set_port(1, 1, 1, 0, 10'h010, 32'h1234);
            run_cycle();
        end
        rst_n = 1'b1;
        idle_ports();
        run_cycle();

        // Single read of the preloaded word
        set_port(0, 1, 0, 0, 10'h3D0, '0);
        run_cycle();
        idle_ports();
        run_cycle();
        run_cycle();

        // Both request every cycle, no lock: strict alternation
        s = hist.size();
        for (int i = 0; i < 6; i++) begin
            set_port(0, 1, 0, 0, AW'(10'h020 + i), '0);
            set_port(1, 1, 0, 0, AW'(10'h040 + i), '0);
            run_cycle();
        end
        for (int i = 1; i < 6; i++) chk("alternate", hist[s + i], 1 - hist[s + i - 1]);

        // Write by m1 then read of the same word by m0
        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 1, 1, 0, 10'h3D1, 32'd4242);
        run_cycle();
        set_port(0, 1, 0, 0, 10'h3D1, '0);
        set_port(1, 0, 0, 0, '0, '0);
        run_cycle();
        idle_ports();
        run_cycle();

        // Make port 1 the last winner, then m0 locks for 12 reads against m1
        set_port(1, 1, 0, 0, 10'h300, '0);
        run_cycle();
        s = hist.size();
        rem = 12;
        n = 0;
        while (rem > 0 && n < 40) begin
            set_port(0, 1, 0, 1, AW'(10'h100 + rem), '0);
            set_port(1, 1, 0, 0, 10'h200, '0);
            run_cycle();
            if (last_g == 0) rem--;
            n++;
        end
        chk("lock_reads_done", rem, 0);
        exp_lock = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        check_hist("lock_seq", s, exp_lock);
        idle_ports();
        run_cycle();

        // Lock owner drops req for one cycle: no grant, then m1 wins
        s = hist.size();
        set_port(0, 1, 0, 1, 10'h050, '0);
        run_cycle();
        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 1, 0, 0, 10'h060, '0);
        run_cycle();
        run_cycle();
        exp_drop = '{0, -1, 1};
        check_hist("lock_drop", s, exp_drop);
        idle_ports();
        run_cycle();

        // Reset right after a locked read grant: response dropped, IDLE, m0 wins tie
        s = hist.size();
        set_port(0, 1, 0, 1, 10'h3D0, '0);
        run_cycle();
        rst_n = 1'b0;
        set_port(1, 1, 0, 0, 10'h070, '0);
        run_cycle();
        rst_n = 1'b1;
        set_port(0, 1, 0, 0, 10'h071, '0);
        run_cycle();
        set_port(0, 1, 0, 1, 10'h072, '0);
        set_port(1, 0, 0, 0, '0, '0);
        run_cycle();
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 1, 0, 0, 10'h073, '0);
        run_cycle();
        exp_rst = '{0, -1, 0, 0, -1, 1};
        check_hist("reset_seq", s, exp_rst);
        idle_ports();
        run_cycle();

        // Randomized traffic; a pending request is held until granted
        pend[0] = 0;
        pend[1] = 0;
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    set_port(p, ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                             ($urandom_range(0, 9) < 4),
                             AW'(10'h3C0 + $urandom_range(0, 31)), $urandom);
                end
            end
            run_cycle();
            pend[0] = bus.m0_req && (last_g != 0);
            pend[1] = bus.m1_req && (last_g != 1);
        end
        rst_n = 1'b1;
        idle_ports();
        run_cycle();
        run_cycle();

        chk("rsp_queue0_empty", rq[0].size(), 0);
        chk("rsp_queue1_empty", rq[1].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word address width into data memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter MAX_LOCK, default 8, max consecutive locked grants to one port (range 1..255).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 mN_req  input  1  port N (N=0,1) access request, held until granted.
REQ-007 mN_we  input  1  port N write (1) / read (0).
REQ-008 mN_lock  input  1  port N requests to keep ownership after this grant.
REQ-009 mN_addr  input  ADDR_W  port N word address.
REQ-010 mN_wdata  input  DATA_W  port N write data.
REQ-011 mN_gnt  output  1  port N access accepted this cycle (combinational).
REQ-012 mN_rvalid  output  1  port N read data valid (registered).
REQ-013 mN_rdata  output  DATA_W  port N read data, 0 when mN_rvalid=0.
REQ-014 mem_addr  output  ADDR_W  memory address.
REQ-015 mem_wdata  output  DATA_W  memory write data.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_rdata  input  DATA_W  memory registered read data (valid cycle after address).

Function
REQ-018 At most one of m0_gnt/m1_gnt SHALL be 1 per cycle; a grant is only given to a port with mN_req=1.
REQ-019 Winner's addr/wdata/we SHALL drive mem_* combinationally in the grant cycle; with no grant mem_we=0, mem_addr=0, mem_wdata=0.
REQ-020 FSM states IDLE, LOCK0, LOCK1; reset state IDLE.
REQ-021 IDLE: single requester wins; both requesting -> port not granted last (last_gnt register, reset value 1, so port 0 wins first tie).
REQ-022 IDLE -> LOCKN when port N granted with mN_lock=1 and MAX_LOCK>1; lock counter loaded with 1.
REQ-023 LOCKN: only port N eligible; other port's request stalls (mX_gnt=0).
REQ-024 LOCKN -> IDLE when mN_req=0 (no grant that cycle), or mN granted with mN_lock=0.
REQ-025 LOCKN: each grant increments counter; grant that brings counter to MAX_LOCK SHALL force IDLE and set last_gnt=N regardless of mN_lock.
REQ-026 Granted read (we=0) in cycle T SHALL produce mN_rvalid=1 and mN_rdata=mem_rdata in cycle T+1 only; fixed latency 1.
REQ-027 Granted write SHALL produce no rvalid; back-to-back grants every cycle SHALL be supported (throughput 1 access/cycle).
REQ-028 last_gnt SHALL update on every grant.

Reset
REQ-029 rst_n=0 at a posedge SHALL set state=IDLE, last_gnt=1, counter=0, m0_rvalid=m1_rvalid=0.
REQ-030 While rst_n=0, mN_gnt=0 and mem_we=0; a read granted in the cycle before reset SHALL NOT return rvalid after reset.
REQ-031 Reset mid-lock SHALL drop ownership; first post-reset cycle arbitrates from IDLE.

Structure
REQ-032 Shared package dmem_arb_pkg SHALL hold the state enum (IDLE, LOCK0, LOCK1) and ADDR_W/DATA_W defaults.
REQ-033 One sub-module rr_pick2 SHALL implement the two-way round-robin pick (req0, req1, last_gnt -> gnt0, gnt1); FSM, counter and response path stay in dmem_arbiter.

Verification
REQ-034 Reset then m0 read addr 0x3D0 (mem holds 2001) -> m0_gnt=1 cycle T, m0_rvalid=1, m0_rdata=2001 in T+1, 0 otherwise.
REQ-035 Both req every cycle, lock=0 -> grants alternate 0,1,0,1; mem_addr follows winner each cycle.
REQ-036 m1 write 0x3D1=4242 then m0 read 0x3D1 next cycle -> m0_rdata=4242.
REQ-037 m0 lock=1 with 12 reads, m1 req constant, MAX_LOCK=8 -> m0 granted 8 consecutive cycles, then m1 granted, then m0.
REQ-038 m0 locked, drops req for one cycle -> no grant that cycle, FSM IDLE, m1 granted next cycle if requesting.
REQ-039 rst_n=0 in cycle after m0 read grant -> m0_rvalid stays 0, state IDLE, next tie grants m0.
